// File: rtl/mem_stage.sv
// mem_stage: EX->MEM->WB stage with synchronous byte-enabled data memory and load formatting.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned LH/LHU/SH/LW/SW and pulse misalign_o.
package mem_stage_pkg;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DMEM_DEPTH     = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result_i,
    input  logic [DATA_WIDTH-1:0]     ex_rd_data2_i,
    input  logic [DATA_WIDTH-1:0]     ex_pc_plus4_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic [2:0]                ex_funct3_i,
    input  logic                      ex_MemRead_i,
    input  logic                      ex_MemWrite_i,
    input  logic                      ex_RegWrite_i,
    input  wb_sel_e                   ex_WBSel_i,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_o,
`endif
    output logic                      WB_RegWrite_w,
    output logic [REG_ADDR_WIDTH-1:0] WB_wr_addr_w,
    output logic [DATA_WIDTH-1:0]     WB_wr_data_w
);
    localparam int AW = $clog2(DMEM_DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic {IDLE, LOAD_WAIT} state_e;

    state_e                    state, state_nxt;
    logic [DATA_WIDTH-1:0]     mem [DMEM_DEPTH];
    logic [DATA_WIDTH-1:0]     rdata, st_data, ld_data;
    logic [AW-1:0]             idx;
    logic [3:0]                be;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [2:0]                ld_funct3;
    logic [1:0]                ld_off;
    logic [REG_ADDR_WIDTH-1:0] ld_rd;
    logic                      ld_we, xfer, is_load, st_mis, ld_mis;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a != 2'b00);
    endfunction

    assign ex_ready_o = state == IDLE;
    assign xfer       = ex_valid_i && ex_ready_o;
    assign is_load    = xfer && ex_MemRead_i;
    assign idx        = ex_alu_result_i[AW+1:2];
    assign st_mis     = TRAP && ex_MemWrite_i && !ex_MemRead_i && misaligned(ex_funct3_i, ex_alu_result_i[1:0]);
    assign ld_mis     = TRAP && misaligned(ld_funct3, ld_off);

    // A load that also has MemWrite set is still just a load.
    always_comb begin
        state_nxt = is_load ? LOAD_WAIT : IDLE;
        be = (!xfer || ex_MemRead_i || !ex_MemWrite_i || st_mis) ? 4'b0000
           : ex_funct3_i == 3'b000 ? 4'b0001 << ex_alu_result_i[1:0]
           : ex_funct3_i == 3'b001 ? (ex_alu_result_i[1] ? 4'b1100 : 4'b0011)
           : ex_funct3_i == 3'b010 ? 4'b1111 : 4'b0000;
        st_data = ex_funct3_i == 3'b000 ? {4{ex_rd_data2_i[7:0]}}
                : ex_funct3_i == 3'b001 ? {2{ex_rd_data2_i[15:0]}} : ex_rd_data2_i;
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = ld_funct3 == 3'b000 ? {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte}
                : ld_funct3 == 3'b001 ? {{(DATA_WIDTH-16){ld_half[15]}}, ld_half}
                : ld_funct3 == 3'b010 ? rdata
                : ld_funct3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                : ld_funct3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, ld_half} : '0;
    end

    // Memory array is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
        if (is_load) rdata <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            WB_RegWrite_w <= 1'b0;
            WB_wr_addr_w  <= '0;
            WB_wr_data_w  <= '0;
            ld_funct3     <= '0;
            ld_off        <= '0;
            ld_rd         <= '0;
            ld_we         <= 1'b0;
        end else begin
            state         <= state_nxt;
            WB_RegWrite_w <= 1'b0;
            if (is_load) begin
                ld_funct3 <= ex_funct3_i;
                ld_off    <= ex_alu_result_i[1:0];
                ld_rd     <= ex_rd_addr_i;
                ld_we     <= ex_RegWrite_i;
            end
            if (state == LOAD_WAIT) begin
                WB_RegWrite_w <= ld_we && ld_rd != '0 && !ld_mis;
                WB_wr_addr_w  <= ld_rd;
                WB_wr_data_w  <= ld_data;
            end else if (xfer && !ex_MemRead_i) begin
                WB_RegWrite_w <= ex_RegWrite_i && ex_rd_addr_i != '0 && !st_mis;
                WB_wr_addr_w  <= ex_rd_addr_i;
                WB_wr_data_w  <= ex_WBSel_i == WB_PC4 ? ex_pc_plus4_i : ex_alu_result_i;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_o <= 1'b0;
        else misalign_o <= state == LOAD_WAIT ? ld_mis : xfer && !ex_MemRead_i && st_mis;
    end
`endif
endmodule
